// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if: valid/ready bundle for N requesters merged onto one downstream channel.
//   up_data  : N*WIDTH requester data, requester i at [i*WIDTH +: WIDTH]
//   up_valid : per-requester valid      up_last : per-requester end-of-packet
//   up_ready : per-requester ready (at most one high)
//   dn_data/dn_id/dn_last/dn_valid : registered merged output   dn_ready : downstream ready
interface stream_rr_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int N = 4,
   parameter int IDW = $clog2(N)
);
   logic [N*WIDTH-1:0] up_data;
   logic [N-1:0] up_valid;
   logic [N-1:0] up_last;
   logic [N-1:0] up_ready;
   logic [WIDTH-1:0] dn_data;
   logic [IDW-1:0] dn_id;
   logic dn_last;
   logic dn_valid;
   logic dn_ready;
   modport master (
      output up_data, up_valid, up_last, dn_ready,
      input up_ready, dn_data, dn_id, dn_last, dn_valid
   );
   modport slave (
      input up_data, up_valid, up_last, dn_ready,
      output up_ready, dn_data, dn_id, dn_last, dn_valid
   );
endinterface

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-locked round-robin merge of N valid/ready streams into one registered output.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave view of stream_rr_arbiter_if (requester side up_*, merged output dn_*)
module stream_rr_arbiter #(
   parameter int WIDTH = 32,
   parameter int N = 4,
   parameter int IDW = $clog2(N)
) (
   input logic clk,
   input logic rst,
   stream_rr_arbiter_if.slave bus
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d, lock_id_q, lock_id_d, dn_id_q, dn_id_d, g, idx;
   logic [WIDTH-1:0] dn_data_q, dn_data_d;
   logic dn_valid_q, dn_valid_d, dn_last_q, dn_last_d;
   logic load_en, any_valid, have_g, accept, g_last;
   logic [N-1:0] ready;
   logic [WIDTH-1:0] up_word [N];
   for (genvar i = 0; i < N; i++) begin : g_word
      assign up_word[i] = bus.up_data[i*WIDTH +: WIDTH];
   end
   assign load_en = !dn_valid_q || bus.dn_ready;
   // Search runs downward so the lowest offset from ptr is the last, winning assignment.
   always_comb begin
      g = ptr_q;
      idx = ptr_q;
      any_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr_q) + k) % N);
         if (bus.up_valid[idx]) begin
            g = idx;
            any_valid = 1'b1;
         end
      end
      if (state_q == LOCKED) g = lock_id_q;
   end
   // In LOCKED the owner is offered ready even when idle, so nobody else can slip in.
   always_comb begin
      have_g = (state_q == LOCKED) || any_valid;
      g_last = bus.up_last[g];
      ready = (have_g && load_en && !rst) ? (N'(1) << g) : '0;
      accept = have_g && load_en && !rst && bus.up_valid[g];
      dn_valid_d = load_en ? accept : dn_valid_q;
      dn_data_d = accept ? up_word[g] : dn_data_q;
      dn_id_d = accept ? g : dn_id_q;
      dn_last_d = accept ? g_last : dn_last_q;
      state_d = accept ? (g_last ? IDLE : LOCKED) : state_q;
      lock_id_d = (accept && !g_last) ? g : lock_id_q;
      ptr_d = (accept && g_last) ? ((g == IDW'(N - 1)) ? '0 : g + 1'b1) : ptr_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= '0;
         lock_id_q <= '0;
         dn_valid_q <= 1'b0;
         dn_data_q <= '0;
         dn_id_q <= '0;
         dn_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         lock_id_q <= lock_id_d;
         dn_valid_q <= dn_valid_d;
         dn_data_q <= dn_data_d;
         dn_id_q <= dn_id_d;
         dn_last_q <= dn_last_d;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) assert ($onehot0(bus.up_ready));
   end
   assign bus.up_ready = ready;
   assign bus.dn_valid = dn_valid_q;
   assign bus.dn_data = dn_data_q;
   assign bus.dn_id = dn_id_q;
   assign bus.dn_last = dn_last_q;
endmodule
